// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and its helpers.
package dmem_port_arbiter_pkg;

   localparam int DMEM_ADDR_WIDTH = 32;
   localparam int DMEM_DATA_WIDTH = 32;
   localparam int DMEM_BE_WIDTH   = DMEM_DATA_WIDTH / 8;
   localparam int DMEM_WAIT_WIDTH = 4;

   localparam logic [DMEM_BE_WIDTH-1:0] DMEM_BE_ALL = '1;

   typedef struct packed {
      logic                       we;
      logic [DMEM_ADDR_WIDTH-1:0] addr;
      logic [DMEM_DATA_WIDTH-1:0] wdata;
      logic [DMEM_BE_WIDTH-1:0]   be;
   } dmem_req_t;

   typedef enum logic {
      OWNER_P0 = 1'b0,
      OWNER_P1 = 1'b1
   } dmem_owner_e;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating starvation counter: counts consecutive cycles a low-priority
// requester is valid but not granted, and raises force_grant once it has
// waited max_wait cycles so the arbiter hands it the port.
module dmem_starve_counter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic granted,
   output logic force_grant
);

   logic [DMEM_WAIT_WIDTH-1:0] wait_cnt;

   // Force is only meaningful while the requester is still asking.
   assign force_grant = (wait_cnt == DMEM_WAIT_WIDTH'(MAX_WAIT)) && req_valid;

   // Count denied cycles, saturate at the limit, restart on grant or idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (!req_valid || granted) begin
         wait_cnt <= '0;
      end else if (wait_cnt != DMEM_WAIT_WIDTH'(MAX_WAIT)) begin
         wait_cnt <= wait_cnt + DMEM_WAIT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM. The memory stage
// (P0) has fixed priority; the debug/DMA loader (P1) is protected from
// starvation by a forced grant. Read data comes back one cycle later and is
// steered to whichever port issued the access.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   input  logic [BE_WIDTH-1:0]   p0_req_be,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rsp_rdata,

   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   input  logic [BE_WIDTH-1:0]   p1_req_be,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rsp_rdata,

   output logic                  sram_enable,
   output logic                  sram_write_enable,
   output logic [ADDR_WIDTH-1:0] sram_address,
   output logic [DATA_WIDTH-1:0] sram_write_data,
   output logic [BE_WIDTH-1:0]   sram_byte_enable,
   input  logic [DATA_WIDTH-1:0] sram_read_data
);

   logic        force_p1;
   logic        grant_p0;
   logic        grant_p1;
   dmem_req_t   sel_req;
   logic        rsp_vld_q;
   logic        rsp_we_q;
   dmem_owner_e rsp_owner_q;

   dmem_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (p1_req_valid),
      .granted     (grant_p1),
      .force_grant (force_p1)
   );

   // Grant decision; nothing is granted while reset is held so the readies
   // and the SRAM strobe stay low during reset.
   always_comb begin
      grant_p1 = 1'b0;
      grant_p0 = 1'b0;
      if (rst) begin
         if (force_p1 || (p1_req_valid && !p0_req_valid)) begin
            grant_p1 = 1'b1;
         end else if (p0_req_valid) begin
            grant_p0 = 1'b1;
         end
      end
   end

   assign p0_req_ready = grant_p0;
   assign p1_req_ready = grant_p1;

   // Route the winning port's fields to the SRAM untouched; idle drives a
   // quiet bus with all byte lanes enabled.
   always_comb begin
      sel_req.we    = 1'b0;
      sel_req.addr  = '0;
      sel_req.wdata = '0;
      sel_req.be    = DMEM_BE_ALL;
      if (grant_p1) begin
         sel_req.we    = p1_req_we;
         sel_req.addr  = p1_req_addr;
         sel_req.wdata = p1_req_wdata;
         sel_req.be    = p1_req_be;
      end else if (grant_p0) begin
         sel_req.we    = p0_req_we;
         sel_req.addr  = p0_req_addr;
         sel_req.wdata = p0_req_wdata;
         sel_req.be    = p0_req_be;
      end
   end

   assign sram_enable       = grant_p0 || grant_p1;
   assign sram_write_enable = sel_req.we;
   assign sram_address      = sel_req.addr;
   assign sram_write_data   = sel_req.wdata;
   assign sram_byte_enable  = sel_req.be;

   // Remember who issued this cycle's access so next cycle's read data can
   // be returned to the right port; reset drops any pending response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_vld_q   <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_owner_q <= OWNER_P0;
      end else begin
         rsp_vld_q   <= sram_enable;
         rsp_we_q    <= sel_req.we;
         rsp_owner_q <= grant_p1 ? OWNER_P1 : OWNER_P0;
      end
   end

   // Response steering: only the owner sees valid, and only reads carry data.
   always_comb begin
      p0_rsp_valid = rsp_vld_q && (rsp_owner_q == OWNER_P0);
      p1_rsp_valid = rsp_vld_q && (rsp_owner_q == OWNER_P1);
      p0_rsp_rdata = '0;
      p1_rsp_rdata = '0;
      if (p0_rsp_valid && !rsp_we_q) begin
         p0_rsp_rdata = sram_read_data;
      end
      if (p1_rsp_valid && !rsp_we_q) begin
         p1_rsp_rdata = sram_read_data;
      end
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data SRAM between two requesters.
  - Port 0 (P0): the memory pipeline stage.
  - Port 1 (P1): the debug/DMA loader.
- Fixed priority to P0, with a starvation counter that forces a P1 grant after MAX_WAIT consecutive lost cycles.
- SRAM read data returns one cycle after the access. The block routes each response back to the requester that issued it.
- Sits between the memory stage and the data SRAM macro.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8.
- MAX_WAIT, 4, consecutive cycles P1 may be denied while valid before it gets a forced grant; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- p0_req_valid  in  1  P0 request present.
- p0_req_ready  out  1  P0 request accepted this cycle.
- p0_req_we  in  1  P0 write enable (1 = store).
- p0_req_addr  in  ADDR_WIDTH  P0 address.
- p0_req_wdata  in  DATA_WIDTH  P0 store data.
- p0_req_be  in  BE_WIDTH  P0 byte enables.
- p0_rsp_valid  out  1  P0 response (one per accepted request).
- p0_rsp_rdata  out  DATA_WIDTH  P0 read data; 0 for writes.
- p1_req_valid, p1_req_ready, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_be: same as the P0 signals, for P1.
- p1_rsp_valid, p1_rsp_rdata: same as the P0 response signals, for P1.
- sram_enable  out  1  SRAM access strobe.
- sram_write_enable  out  1  SRAM write.
- sram_address  out  ADDR_WIDTH  SRAM address.
- sram_write_data  out  DATA_WIDTH  SRAM write data.
- sram_byte_enable  out  BE_WIDTH  SRAM byte lanes.
- sram_read_data  in  DATA_WIDTH  valid the cycle after a read access.

Behaviour:
- Grant decision is combinational. Request outputs to the SRAM are combinational from the granted port.
  - At most one of p0_req_ready and p1_req_ready is 1 per cycle.
  - A request is accepted when valid && ready.
- Grant rule:
  - force = (wait_cnt == MAX_WAIT) && p1_req_valid.
  - grant P1 if force, or if p1_req_valid && !p0_req_valid.
  - Otherwise grant P0 if p0_req_valid.
  - Otherwise no grant.
- No grant: sram_enable = 0, sram_write_enable = 0, address/wdata = 0, byte_enable = all ones.
- Grant: sram_enable = 1. The SRAM signals mirror the granted port's we/addr/wdata/be unchanged; no arithmetic is performed.
- wait_cnt (4 bits):
  - Increments (saturating at MAX_WAIT) each cycle p1_req_valid = 1 and P1 is not granted.
  - Clears to 0 when P1 is granted or when p1_req_valid = 0.
- Response pipeline: one register stage.
  - rsp_owner_q captures the granted port; rsp_vld_q captures the grant; rsp_we_q captures we.
  - Cycle N+1 after acceptance at N:
    - pX_rsp_valid = 1 for the owner only.
    - pX_rsp_rdata = sram_read_data for a read, 0 for a write.
  - Non-owner rdata = 0.
  - Responses have no backpressure; requesters must sink them.
- Back-to-back: a new grant in cycle N+1 overlaps the response of cycle N. Full throughput is one access per cycle.
- Simultaneous P0 and P1 valid with force active: P1 wins. p0_req_ready = 0, and P0 must hold its request stable.
- Requesters must hold their request stable until ready. The arbiter does not latch request fields.
- Reset (rst = 0, async):
  - wait_cnt = 0, rsp_vld_q = 0, rsp_owner_q = 0.
  - All rsp_valid = 0; all SRAM outputs = 0 except byte_enable = all ones.
  - An in-flight response is dropped and not replayed.
  - While in reset, ready outputs are 0.
- Release from reset: behaviour is normal from the first rising edge with rst = 1.

Decomposition:
- Shared package gets:
  - typedef dmem_req_t {we, addr, wdata, be};
  - typedef enum logic {OWNER_P0, OWNER_P1} dmem_owner_e;
  - localparam DMEM_BE_ALL = '1.
- Sub-module: dmem_starve_counter, holding the saturating wait counter and force output. It is reused later for the instruction-port arbiter.
- Everything else stays flat.

Test Plan:
- P0 only, read at addr 0x100 while SRAM returns 0xDEADBEEF the next cycle -> p0_req_ready = 1 in cycle N; p0_rsp_valid = 1 with rdata 0xDEADBEEF in N+1; p1_rsp_valid stays 0.
- P0 store addr 0x20, wdata 0x11223344, be 4'b0011 -> sram_enable = 1, sram_write_enable = 1, be 4'b0011 in N; p0_rsp_valid = 1 with rdata 0 in N+1.
- P0 and P1 both valid continuously, MAX_WAIT = 4 -> P0 granted 4 cycles, P1 granted on the 5th, then the pattern repeats every 5 cycles; ready never 1 on both ports.
- Alternating back-to-back reads P0 0x0, P1 0x4, P0 0x8 with P1 valid only in its cycle -> responses arrive in order on the matching port, one per cycle, with no bubbles.
- Assert rst low the cycle after P1 read acceptance -> p1_rsp_valid never pulses; after release, wait_cnt = 0 and the first P0 request is granted.
- P1 valid alone for 10 cycles with P0 idle -> P1 granted every cycle and wait_cnt stays 0.
